// File: rtl/scan_link_scheduler_if.sv
// Scanner/link bundle between the control station scanners and the link scheduler.
// The master side is the station (scanners plus downstream ready); the slave is the scheduler.
interface scan_link_scheduler_if;
    logic [6:0] level0;
    logic [6:0] level1;
    logic       dataValid0;
    logic       dataValid1;
    logic [7:0] dataByte0;
    logic [7:0] dataByte1;
    logic       asciiMode0;
    logic       asciiMode1;
    logic       linkReady;
    logic       dataOut;
    logic       frameSync;
    logic       dataAck0;
    logic       dataAck1;
    logic       grantId;
    logic       busy;

    modport master (
        output level0, level1, dataValid0, dataValid1, dataByte0, dataByte1,
               asciiMode0, asciiMode1, linkReady,
        input  dataOut, frameSync, dataAck0, dataAck1, grantId, busy
    );

    modport slave (
        input  level0, level1, dataValid0, dataValid1, dataByte0, dataByte1,
               asciiMode0, asciiMode1, linkReady,
        output dataOut, frameSync, dataAck0, dataAck1, grantId, busy
    );
endinterface

// File: rtl/scan_link_scheduler.sv
// Serial link scheduler: every 8-clock frame carries one byte, chosen at the load
// edge (slot 7) from a pending data byte, a buffer-status code, a data header, or idle.
// Header and its data byte always go out in adjacent frames.
module scan_link_scheduler (
    input  logic                  clk,
    input  logic                  rst,
    scan_link_scheduler_if.slave  link
);

    typedef enum logic {
        ST_IDLE = 1'b0,   // no data byte owed to the line
        ST_DATA = 1'b1    // header sent, latched data byte goes out next frame
    } state_e;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_STATUS,
        SEL_HDR,
        SEL_DATA
    } sel_e;

    localparam logic [7:0] IDLE_BYTE = 8'h00;
    localparam logic [7:0] HDR_BIN   = 8'h07;
    localparam logic [7:0] HDR_ASCII = 8'h08;

    // Buffer fill percent to reporting zone (0: <50, 1: 50-79, 2: 80-89, 3: 90-99, 4: full).
    function automatic logic [2:0] zone_of(input logic [6:0] lvl);
        if (lvl >= 7'd100)     return 3'd4;
        else if (lvl >= 7'd90) return 3'd3;
        else if (lvl >= 7'd80) return 3'd2;
        else if (lvl >= 7'd50) return 3'd1;
        else                   return 3'd0;
    endfunction

    state_e     state_q, state_d;
    sel_e       sel;
    logic [2:0] slot_cnt_q;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] rep_zone_q, rep_zone_d;
    logic [7:0] hold_byte_q, hold_byte_d;
    logic       grant_id_q, grant_id_d;
    logic       last_grant_q, last_grant_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;

    logic       load;
    logic [2:0] zone0, zone1, max_zone;
    logic       any_valid;
    logic       grant;

    assign load      = (slot_cnt_q == 3'd7);
    assign zone0     = zone_of(link.level0);
    assign zone1     = zone_of(link.level1);
    assign max_zone  = (zone0 > zone1) ? zone0 : zone1;
    assign any_valid = link.dataValid0 | link.dataValid1;

    // Round-robin pick: favour the scanner that did not win last time, fall back to the valid one.
    always_comb begin
        if (last_grant_q == 1'b0) grant = link.dataValid1;
        else                      grant = ~link.dataValid0;
    end

    // State register: the pair ordering lives here; reset drops any owed data byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops update from pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state and byte selection, priority: owed data, rising status, new header, idle.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        state_d = state_q;
        sel     = SEL_IDLE;
        if (load) begin
            if (state_q == ST_DATA) begin
                sel     = SEL_DATA;
                state_d = ST_IDLE;
            end else if (max_zone > rep_zone_q) begin
                sel = SEL_STATUS;
            end else if (link.linkReady && any_valid) begin
                sel     = SEL_HDR;
                state_d = ST_DATA;
            end
        end
    end

    // Datapath updates driven by the selected byte: shifter load, zone tracking, grant and acks.
    always_comb begin
        tx_shift_d   = {tx_shift_q[6:0], 1'b0};
        rep_zone_d   = rep_zone_q;
        hold_byte_d  = hold_byte_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;
        if (load) begin
            // A falling zone is tracked silently so a later rise is reported again.
            if (max_zone < rep_zone_q) rep_zone_d = max_zone;
            busy_d = (sel == SEL_HDR) || (sel == SEL_DATA);
            case (sel)
                SEL_DATA: begin
                    tx_shift_d = hold_byte_q;
                end
                SEL_STATUS: begin
                    tx_shift_d = {5'd0, max_zone};
                    rep_zone_d = max_zone;
                end
                SEL_HDR: begin
                    tx_shift_d   = (grant ? link.asciiMode1 : link.asciiMode0) ? HDR_ASCII : HDR_BIN;
                    hold_byte_d  = grant ? link.dataByte1 : link.dataByte0;
                    ack0_d       = ~grant;
                    ack1_d       = grant;
                    grant_id_d   = grant;
                    last_grant_d = grant;
                end
                default: begin
                    tx_shift_d = IDLE_BYTE;
                end
            endcase
        end
    end

    // Datapath registers; lastGrant resets to 1 so scanner 0 wins the first grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= 3'd0;
            tx_shift_q   <= 8'h00;
            rep_zone_q   <= 3'd0;
            hold_byte_q  <= 8'h00;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_q + 3'd1;
            tx_shift_q   <= tx_shift_d;
            rep_zone_q   <= rep_zone_d;
            hold_byte_q  <= hold_byte_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign link.dataOut   = tx_shift_q[7];
    assign link.frameSync = (slot_cnt_q == 3'd0);
    assign link.dataAck0  = ack0_q;
    assign link.dataAck1  = ack1_q;
    assign link.grantId   = grant_id_q;
    assign link.busy      = busy_q;

endmodule
